branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- ID-stage branch resolution unit, directly downstream of the signed operand comparator.
- Consumes the comparator's 2-bit relation code (0: A<B, 1: A==B, 2: A>B) plus the decoded branch type, and decides taken/not-taken.
- Computes the branch target and raises the operand-hazard stall.
- Tracks the architectural delay slot and keeps branch/taken performance counters.
- Drives the IF-stage next-PC mux and the hazard unit.

Parameters:
- CNT_W, 32, width of the performance counters br_cnt and taken_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- id_valid  in  1  ID stage holds a valid instruction.
- br_type  in  3  branch type: 0 NONE, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 reserved (treated as NONE).
- pd  in  2  comparator result: 0 lt, 1 eq, 2 gt, 3 illegal.
- opnd_ready  in  1  forwarding unit reports that both comparator operands are current.
- stall_in  in  1  downstream pipeline stall; ID must hold.
- pc_id  in  32  PC of the ID-stage instruction.
- imm16  in  16  branch offset field.
- br_taken  out  1  select br_target for the next PC (Mealy output).
- br_target  out  32  pc_id + 4 + (sext(imm16) << 2), modulo 2^32.
- id_stall  out  1  freeze PC, IF/ID and ID stage.
- ds_err  out  1  sticky flag: branch in delay slot, or illegal pd.
- br_cnt  out  CNT_W  number of resolved branches.
- taken_cnt  out  CNT_W  number of taken branches.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, ds_err=0, br_cnt=0, taken_cnt=0.
  - br_taken=0 and id_stall=0 while in reset.
- States: IDLE, WAIT_OPND, DSLOT.
- is_br = id_valid & (br_type in 1..6).
- Condition from pd:
  - BEQ: pd==1. BNE: pd!=1.
  - BLEZ: pd!=2. BGTZ: pd==2.
  - BLTZ: pd==0. BGEZ: pd!=0.
  - pd==3 forces not taken and sets ds_err.
- resolve = is_br & opnd_ready & !stall_in, plus in DSLOT the branch must not be the delay-slot instruction itself (see DSLOT).
- br_taken = resolve & cond, combinational in the resolving cycle. The PC takes br_target at that clock edge, so zero added latency.
- br_target is always driven combinationally from pc_id/imm16, regardless of br_type.
- id_stall = is_br & !opnd_ready. The operand hazard overrides stall_in, and both may be high together.
- IDLE:
  - is_br & !opnd_ready -> WAIT_OPND.
  - resolve -> DSLOT.
  - otherwise stay.
- WAIT_OPND:
  - id_stall stays high until opnd_ready.
  - resolve -> DSLOT.
  - !id_valid (ID flushed/bubbled) -> IDLE.
- DSLOT (delay-slot instruction now in ID):
  - If is_br: ds_err=1, br_taken=0, no counter increment, no stall; the instruction is treated as NONE.
  - Leave to IDLE on the first cycle with id_valid & !stall_in.
  - While stall_in is high, stay.
- Counters (on resolve only):
  - br_cnt += 1.
  - taken_cnt += cond.
  - Both wrap modulo 2^CNT_W.
- ds_err stays set until reset.
- Reset mid-WAIT_OPND or mid-DSLOT returns to IDLE immediately; the pending branch is dropped with no counter update.

Decomposition:
- Shared package constants: br_type encodings (BR_NONE..BR_BGEZ), pd codes (PD_LT=0, PD_EQ=1, PD_GT=2), state encodings.
- Condition evaluation (br_type, pd -> cond, illegal) is a natural pure-combinational sub-module: br_cond.
- FSM, target adder and counters stay in branch_resolve.

Test Plan:
- BEQ, pd=1, opnd_ready=1, pc_id=0x00003000, imm16=0x0004:
  - br_taken=1, br_target=0x00003014 in the same cycle.
  - Next cycle state DSLOT, br_cnt=1, taken_cnt=1.
- BNE, pd=1, and BGEZ, pd=0:
  - br_taken=0 in both cases.
  - br_cnt increments each time; taken_cnt unchanged.
- BLTZ, imm16=0xFFFF, pc_id=0x00003000:
  - br_target=0x00003000.
  - pc_id=0xFFFFFFFC, imm16=0 gives br_target=0x00000000 (wrap).
- BGTZ with opnd_ready=0 for 3 cycles, then 1 with pd=2:
  - id_stall=1 for exactly those 3 cycles.
  - br_taken=1 on the 4th cycle.
  - Counters increment once.
- Taken BEQ followed by BNE in the delay slot:
  - ds_err=1.
  - br_taken=0 for the BNE; br_cnt=1.
- pd=3 on a BEQ sets ds_err=1 with br_taken=0.
- reset=0 asserted asynchronously while in WAIT_OPND: id_stall, br_taken and the counters drop to 0 without a clock edge.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the ID-stage branch resolution slice: branch types,
// comparator relation codes, FSM states and the branch target helper.
package branch_resolve_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_type_e;

  localparam logic [1:0] PD_LT  = 2'd0;
  localparam logic [1:0] PD_EQ  = 2'd1;
  localparam logic [1:0] PD_GT  = 2'd2;
  localparam logic [1:0] PD_ILL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_OPND = 2'd1,
    ST_DSLOT     = 2'd2
  } state_e;

  // Word-aligned PC-relative target: pc + 4 + sext(imm) * 4, wrapping at 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_resolve_cond.sv
// Pure combinational branch condition evaluation from the decoded branch
// type and the comparator relation code.
module br_cond
  import branch_resolve_pkg::*;
(
  input  logic [2:0] br_type_i,
  input  logic [1:0] pd_i,
  output logic       is_br_type_o,
  output logic       cond_o,
  output logic       illegal_o
);

  logic raw_cond;

  // Decode branch type and evaluate the raw relation test.
  always_comb begin
    is_br_type_o = 1'b1;
    raw_cond     = 1'b0;
    case (br_type_e'(br_type_i))
      BR_BEQ:  raw_cond = (pd_i == PD_EQ);
      BR_BNE:  raw_cond = (pd_i != PD_EQ);
      BR_BLEZ: raw_cond = (pd_i != PD_GT);
      BR_BGTZ: raw_cond = (pd_i == PD_GT);
      BR_BLTZ: raw_cond = (pd_i == PD_LT);
      BR_BGEZ: raw_cond = (pd_i != PD_LT);
      default: begin
        is_br_type_o = 1'b0;
        raw_cond     = 1'b0;
      end
    endcase
  end

  // An illegal relation code can never produce a taken branch.
  always_comb begin
    illegal_o = (pd_i == PD_ILL);
    cond_o    = raw_cond & ~illegal_o;
  end

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch resolution: taken decision, target, operand-hazard stall,
// delay-slot tracking and branch/taken performance counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [2:0]       br_type,
  input  logic [1:0]       pd,
  input  logic             opnd_ready,
  input  logic             stall_in,
  input  logic [31:0]      pc_id,
  input  logic [15:0]      imm16,
  output logic             br_taken,
  output logic [31:0]      br_target,
  output logic             id_stall,
  output logic             ds_err,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_e           state_q, state_d;
  logic             ds_err_q, ds_err_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic is_br_type, cond, illegal;
  logic is_br, in_dslot, resolve;

  br_cond u_br_cond (
    .br_type_i    (br_type),
    .pd_i         (pd),
    .is_br_type_o (is_br_type),
    .cond_o       (cond),
    .illegal_o    (illegal)
  );

  // A branch sitting in the delay slot is demoted to NONE, so it never resolves.
  always_comb begin
    is_br    = id_valid & is_br_type;
    in_dslot = (state_q == ST_DSLOT);
    resolve  = is_br & opnd_ready & ~stall_in & ~in_dslot;
  end

  // Mealy outputs; gated by reset so nothing escapes while the unit is held.
  always_comb begin
    br_taken  = reset & resolve & cond;
    id_stall  = reset & is_br & ~opnd_ready & ~in_dslot;
    br_target = branch_target(pc_id, imm16);
    ds_err    = ds_err_q;
    br_cnt    = br_cnt_q;
    taken_cnt = taken_cnt_q;
  end

  // Next-state logic for the resolution FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (resolve) begin
          state_d = ST_DSLOT;
        end else if (is_br & ~opnd_ready) begin
          state_d = ST_WAIT_OPND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_OPND: begin
        if (resolve) begin
          state_d = ST_DSLOT;
        end else if (~id_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_OPND;
        end
      end
      ST_DSLOT: begin
        if (id_valid & ~stall_in) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DSLOT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky error flag and performance counters, updated only on resolve.
  always_comb begin
    ds_err_d    = ds_err_q | (in_dslot & is_br) | (resolve & illegal);
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (resolve) begin
      br_cnt_d = br_cnt_q + CNT_ONE;
      if (cond) begin
        taken_cnt_d = taken_cnt_q + CNT_ONE;
      end else begin
        taken_cnt_d = taken_cnt_q;
      end
    end else begin
      br_cnt_d    = br_cnt_q;
      taken_cnt_d = taken_cnt_q;
    end
  end

  // State and bookkeeping registers; reset drops any pending branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ds_err_q    <= 1'b0;
      br_cnt_q    <= CNT_ZERO;
      taken_cnt_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      ds_err_q    <= ds_err_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed scoreboard bench for branch_resolve: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_branch_resolve;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [2:0]  br_type;
  logic [1:0]  pd;
  logic        opnd_ready;
  logic        stall_in;
  logic [31:0] pc_id;
  logic [15:0] imm16;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_stall;
  logic        ds_err;
  logic [31:0] br_cnt;
  logic [31:0] taken_cnt;

  typedef struct {
    int          id;
    logic        taken;
    logic [31:0] target;
    logic        stall;
    logic        dserr;
    logic [31:0] brc;
    logic [31:0] tkc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  branch_resolve #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .br_type    (br_type),
    .pd         (pd),
    .opnd_ready (opnd_ready),
    .stall_in   (stall_in),
    .pc_id      (pc_id),
    .imm16      (imm16),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .id_stall   (id_stall),
    .ds_err     (ds_err),
    .br_cnt     (br_cnt),
    .taken_cnt  (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", id, nm, act, req);
    end
  endtask

  // Monitor: compare whatever expectation is pending at each falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.id, "br_taken",  {31'd0, br_taken}, {31'd0, e.taken});
      chk(e.id, "br_target", br_target, e.target);
      chk(e.id, "id_stall",  {31'd0, id_stall}, {31'd0, e.stall});
      chk(e.id, "ds_err",    {31'd0, ds_err},   {31'd0, e.dserr});
      chk(e.id, "br_cnt",    br_cnt, e.brc);
      chk(e.id, "taken_cnt", taken_cnt, e.tkc);
    end
  end

  int vec_id = 0;

  task automatic drive(input logic rst, input logic v, input logic [2:0] t, input logic [1:0] p,
                       input logic rdy, input logic st, input logic [31:0] pc, input logic [15:0] imm,
                       input logic e_tk, input logic [31:0] e_tg, input logic e_st, input logic e_ds,
                       input logic [31:0] e_br, input logic [31:0] e_tc);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst;
    id_valid   = v;
    br_type    = t;
    pd         = p;
    opnd_ready = rdy;
    stall_in   = st;
    pc_id      = pc;
    imm16      = imm;
    e.id     = vec_id;
    e.taken  = e_tk;
    e.target = e_tg;
    e.stall  = e_st;
    e.dserr  = e_ds;
    e.brc    = e_br;
    e.tkc    = e_tc;
    exp_q.push_back(e);
    vec_id++;
  endtask

  localparam logic [31:0] PC0 = 32'h0000_3000;
  localparam logic [31:0] T0  = 32'h0000_3014;

  initial begin
    reset = 1'b0; id_valid = 1'b0; br_type = 3'd0; pd = 2'd0;
    opnd_ready = 1'b0; stall_in = 1'b0; pc_id = 32'd0; imm16 = 16'd0;
    repeat (2) @(posedge clk);
    //     rst   v     type  pd    rdy   stall pc                imm         tk    target          st    ds    br     tk
    drive(1'b0, 1'b1, 3'd1, 2'd1, 1'b1, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b0, 32'd0, 32'd0);
    // taken BEQ, then delay slot
    drive(1'b1, 1'b1, 3'd1, 2'd1, 1'b1, 1'b0, PC0,              16'h0004,   1'b1, T0,             1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 32'h0000_3004,    16'h0000,   1'b0, 32'h0000_3008,  1'b0, 1'b0, 32'd1, 32'd1);
    // BNE pd=eq and BGEZ pd=lt, both not taken
    drive(1'b1, 1'b1, 3'd2, 2'd1, 1'b1, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b0, 32'd1, 32'd1);
    drive(1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b0, 32'd2, 32'd1);
    drive(1'b1, 1'b1, 3'd6, 2'd0, 1'b1, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b0, 32'd2, 32'd1);
    drive(1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b0, 32'd3, 32'd1);
    // BLTZ with negative offset, then target wrap while delay slot is stalled
    drive(1'b1, 1'b1, 3'd5, 2'd0, 1'b1, 1'b0, PC0,              16'hFFFF,   1'b1, 32'h0000_3000,  1'b0, 1'b0, 32'd3, 32'd1);
    drive(1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b1, 32'hFFFF_FFFC,    16'h0000,   1'b0, 32'h0000_0000,  1'b0, 1'b0, 32'd4, 32'd2);
    drive(1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b0, 32'd4, 32'd2);
    // downstream stall blocks resolution without raising id_stall
    drive(1'b1, 1'b1, 3'd1, 2'd1, 1'b1, 1'b1, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b0, 32'd4, 32'd2);
    // BGTZ operand hazard for 3 cycles, then taken
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b1, 3'd4, 2'd0, 1'b0, 1'b0, PC0,            16'h0004,   1'b0, T0,             1'b1, 1'b0, 32'd4, 32'd2);
    drive(1'b1, 1'b1, 3'd4, 2'd2, 1'b1, 1'b0, PC0,              16'h0004,   1'b1, T0,             1'b0, 1'b0, 32'd4, 32'd2);
    drive(1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b0, 32'd5, 32'd3);
    // hazard and downstream stall together, then async reset mid-cycle in WAIT_OPND
    drive(1'b1, 1'b1, 3'd1, 2'd1, 1'b0, 1'b1, PC0,              16'h0004,   1'b0, T0,             1'b1, 1'b0, 32'd5, 32'd3);
    drive(1'b0, 1'b1, 3'd1, 2'd1, 1'b0, 1'b1, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b0, 32'd0, 32'd0);
    // taken BEQ followed by BNE in the delay slot
    drive(1'b1, 1'b1, 3'd1, 2'd1, 1'b1, 1'b0, PC0,              16'h0004,   1'b1, T0,             1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 3'd2, 2'd1, 1'b0, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b0, 32'd1, 32'd1);
    drive(1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b1, 32'd1, 32'd1);
    // reset clears sticky ds_err; then illegal pd on BEQ
    drive(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 3'd1, 2'd3, 1'b1, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b1, 32'd1, 32'd0);
    // BLEZ taken on eq
    drive(1'b1, 1'b1, 3'd3, 2'd1, 1'b1, 1'b0, PC0,              16'h0004,   1'b1, T0,             1'b0, 1'b1, 32'd1, 32'd0);
    drive(1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b1, 32'd2, 32'd1);
    // WAIT_OPND abandoned by a bubble; reserved type behaves as NONE
    drive(1'b1, 1'b1, 3'd1, 2'd1, 1'b0, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b1, 1'b1, 32'd2, 32'd1);
    drive(1'b1, 1'b0, 3'd1, 2'd1, 1'b0, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b1, 32'd2, 32'd1);
    drive(1'b1, 1'b1, 3'd7, 2'd1, 1'b0, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b1, 32'd2, 32'd1);
    drive(1'b1, 1'b1, 3'd1, 2'd0, 1'b1, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b1, 32'd2, 32'd1);
    drive(1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, PC0,              16'h0004,   1'b0, T0,             1'b0, 1'b1, 32'd3, 32'd1);
    @(negedge clk);
    #1;
    chk(-1, "scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
